mat_mult_sched: RTL

- Round-robin scheduler that shares one mat_mult engine between N_REQ requesters, such as band-covariance, projection and whitening stages.
- Arbitrates and latches the winner's dimensions and MAC mode, then pulses the engine's start.
- Steers the winner's operand streams into the engine and routes the engine's `done` back as a per-requester completion pulse.
- Sits between the requester stages and the single mat_mult instance.

---
 rtl/mat_mult_pkg.sv | 37 +++
 rtl/mat_mult_sched_rr_arbiter.sv | 44 ++++
 rtl/mat_mult_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mat_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mat_mult_pkg
//  Purpose  : Shared definitions for the mat_mult engine and its scheduler:
//             scheduler state encoding, operand/dimension width helpers and
//             the 3-bit MAC mode codes understood by mat_mult.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mat_mult_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } sched_state_t;

  // Dimension field width for a maximum matrix size of 'bands'
  function automatic int aw_f(input int bands);
    return (bands > 1) ? $clog2(bands) : 1;
  endfunction

  // Operand word width (integer + fractional bits)
  function automatic int dw_f(input int i_width, input int f_width);
    return i_width + f_width;
  endfunction

  // MAC modes shared with mat_mult
  localparam logic [2:0] c_MAC_MODE_MUL     = 3'd0;  // plain product
  localparam logic [2:0] c_MAC_MODE_ACC     = 3'd1;  // accumulate into result
  localparam logic [2:0] c_MAC_MODE_SUB     = 3'd2;  // subtract from result
  localparam logic [2:0] c_MAC_MODE_TRANS   = 3'd3;  // mat1 transposed
  localparam logic [2:0] c_MAC_MODE_SYMM    = 3'd4;  // symmetric output (upper only)

endpackage
`default_nettype wire

// File: rtl/mat_mult_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick over N_REQ request bits. The
//             search starts at i_rr_ptr and wraps modulo N_REQ.
//  Ports    : i_req     - request vector
//             i_rr_ptr  - index with highest priority this cycle
//             o_grant   - one-hot winner (all zero when no request)
//             o_idx     - binary index of the winner
//             o_any     - at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int c_IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [c_IW-1:0]  i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [c_IW-1:0]  o_idx,
  output logic             o_any
);

  // rr_ptr is always < N_REQ, so ptr+k never exceeds 2*N_REQ-2 and one
  // conditional subtraction is enough to wrap.
  function automatic int f_wrap(input int v);
    return (v >= N_REQ) ? (v - N_REQ) : v;
  endfunction

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && i_req[f_wrap(int'(i_rr_ptr) + k)]) begin
        o_any                             = 1'b1;
        o_idx                             = c_IW'(f_wrap(int'(i_rr_ptr) + k));
        o_grant[f_wrap(int'(i_rr_ptr) + k)] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mat_mult_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mat_mult_sched
//  Purpose  : Round-robin scheduler sharing one mat_mult engine between
//             N_REQ requesters. Latches the winner's dims/mode, pulses
//             eng_start, steers the winner's operand streams to the engine
//             and returns eng_done as a per-requester req_done pulse.
//  Ports    : clk, rst (sync, active low)
//             req/req_rows/req_cols/req_cols2/req_mode - per-requester jobs
//             req_mat1/2, req_mat1/2_valid             - per-requester operands
//             req_done/req_err                         - completion / reject
//             grant_valid/grant_id                     - current owner
//             eng_*                                    - engine side
//  Options  : MM_SCHED_TIMEOUT_EN - BUSY watchdog of TIMEOUT_CYCLES that
//             aborts the engine and reports req_err to the owner.
//  Revision : 1.0  initial release
// ============================================================================
module mat_mult_sched
  import mat_mult_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int I_WIDTH        = 16,
  parameter  int F_WIDTH        = 16,
  parameter  int SPECTRAL_BANDS = 103,
  parameter  int TIMEOUT_CYCLES = 2**20,
  localparam int c_AW = aw_f(SPECTRAL_BANDS),
  localparam int c_DW = dw_f(I_WIDTH, F_WIDTH),
  localparam int c_IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*c_AW-1:0]   req_rows,
  input  logic [N_REQ*c_AW-1:0]   req_cols,
  input  logic [N_REQ*c_AW-1:0]   req_cols2,
  input  logic [N_REQ*3-1:0]      req_mode,
  input  logic [N_REQ*c_DW-1:0]   req_mat1,
  input  logic [N_REQ*c_DW-1:0]   req_mat2,
  input  logic [N_REQ-1:0]        req_mat1_valid,
  input  logic [N_REQ-1:0]        req_mat2_valid,
  output logic [N_REQ-1:0]        req_done,
  output logic [N_REQ-1:0]        req_err,
  output logic                    grant_valid,
  output logic [c_IW-1:0]         grant_id,
  output logic                    eng_start,
  output logic [c_AW-1:0]         eng_rows,
  output logic [c_AW-1:0]         eng_cols,
  output logic [c_AW-1:0]         eng_cols2,
  output logic [2:0]              eng_mode,
  output logic [c_DW-1:0]         eng_mat1,
  output logic [c_DW-1:0]         eng_mat2,
  output logic                    eng_mat1_valid,
  output logic                    eng_mat2_valid,
  input  logic                    eng_done,
  output logic                    eng_abort
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("mat_mult_sched: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  sched_state_t      r_state, w_state_nxt;
  logic [c_IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [c_IW-1:0]   r_grant_id, w_grant_id_nxt;
  logic              r_grant_valid, w_grant_valid_nxt;
  logic              r_eng_start, w_eng_start_nxt;
  logic [N_REQ-1:0]  r_req_done, w_req_done_nxt;
  logic [N_REQ-1:0]  r_req_err, w_req_err_nxt;
  logic [c_AW-1:0]   r_rows, r_cols, r_cols2;
  logic [c_AW-1:0]   w_rows_nxt, w_cols_nxt, w_cols2_nxt;
  logic [2:0]        r_mode, w_mode_nxt;

  logic [N_REQ-1:0]  w_arb_grant;
  logic [c_IW-1:0]   w_arb_idx;
  logic              w_arb_any;
  logic [c_AW-1:0]   w_cand_rows, w_cand_cols, w_cand_cols2;
  logic [2:0]        w_cand_mode;
  logic              w_dim_bad;

`ifdef MM_SCHED_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [c_TW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_eng_abort, w_eng_abort_nxt;
`endif

  function automatic logic [c_IW-1:0] f_next_ptr(input logic [c_IW-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : (p + c_IW'(1));
  endfunction

  rr_arbiter #(
    .N_REQ    (N_REQ)
  ) u_arb (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_arb_grant),
    .o_idx    (w_arb_idx),
    .o_any    (w_arb_any)
  );

  assign w_cand_rows  = req_rows [int'(w_arb_idx)*c_AW +: c_AW];
  assign w_cand_cols  = req_cols [int'(w_arb_idx)*c_AW +: c_AW];
  assign w_cand_cols2 = req_cols2[int'(w_arb_idx)*c_AW +: c_AW];
  assign w_cand_mode  = req_mode [int'(w_arb_idx)*3    +: 3];

  // Compare in 32 bits: SPECTRAL_BANDS may equal 2**c_AW and not fit c_AW.
  assign w_dim_bad = (32'(w_cand_rows)  >= SPECTRAL_BANDS) ||
                     (32'(w_cand_cols)  >= SPECTRAL_BANDS) ||
                     (32'(w_cand_cols2) >= SPECTRAL_BANDS);

  always_comb begin
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_eng_start_nxt   = 1'b0;
    w_req_done_nxt    = '0;
    w_req_err_nxt     = '0;
    w_rows_nxt        = r_rows;
    w_cols_nxt        = r_cols;
    w_cols2_nxt       = r_cols2;
    w_mode_nxt        = r_mode;
`ifdef MM_SCHED_TIMEOUT_EN
    w_cnt_nxt         = r_cnt;
    w_eng_abort_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          if (w_dim_bad) begin
            // Reject and move priority past the offender so it cannot
            // starve the others while it keeps its bad request up.
            w_req_err_nxt = w_arb_grant;
            w_rr_ptr_nxt  = f_next_ptr(w_arb_idx);
          end else begin
            w_grant_id_nxt    = w_arb_idx;
            w_grant_valid_nxt = 1'b1;
            w_rows_nxt        = w_cand_rows;
            w_cols_nxt        = w_cand_cols;
            w_cols2_nxt       = w_cand_cols2;
            w_mode_nxt        = w_cand_mode;
            w_state_nxt       = START;
          end
        end
      end
      START: begin
        w_eng_start_nxt = 1'b1;
        w_state_nxt     = BUSY;
`ifdef MM_SCHED_TIMEOUT_EN
        w_cnt_nxt       = '0;
`endif
      end
      BUSY: begin
        if (eng_done) begin
          w_req_done_nxt[r_grant_id] = 1'b1;
          w_grant_valid_nxt          = 1'b0;
          w_rr_ptr_nxt               = f_next_ptr(r_grant_id);
          w_state_nxt                = IDLE;
        end
`ifdef MM_SCHED_TIMEOUT_EN
        // Counter is about to reach TIMEOUT_CYCLES-1: abort this cycle.
        else if (r_cnt == c_TW'(TIMEOUT_CYCLES - 2)) begin
          w_eng_abort_nxt           = 1'b1;
          w_req_err_nxt[r_grant_id] = 1'b1;
          w_grant_valid_nxt         = 1'b0;
          w_rr_ptr_nxt              = f_next_ptr(r_grant_id);
          w_state_nxt               = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_TW'(1);
        end
`endif
      end
      default: begin
        w_state_nxt       = IDLE;
        w_grant_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_eng_start   <= 1'b0;
      r_req_done    <= '0;
      r_req_err     <= '0;
      r_rows        <= '0;
      r_cols        <= '0;
      r_cols2       <= '0;
      r_mode        <= c_MAC_MODE_MUL;
`ifdef MM_SCHED_TIMEOUT_EN
      r_cnt         <= '0;
      r_eng_abort   <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_eng_start   <= w_eng_start_nxt;
      r_req_done    <= w_req_done_nxt;
      r_req_err     <= w_req_err_nxt;
      r_rows        <= w_rows_nxt;
      r_cols        <= w_cols_nxt;
      r_cols2       <= w_cols2_nxt;
      r_mode        <= w_mode_nxt;
`ifdef MM_SCHED_TIMEOUT_EN
      r_cnt         <= w_cnt_nxt;
      r_eng_abort   <= w_eng_abort_nxt;
`endif
    end
  end

  assign req_done    = r_req_done;
  assign req_err     = r_req_err;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign eng_start   = r_eng_start;
  assign eng_rows    = r_rows;
  assign eng_cols    = r_cols;
  assign eng_cols2   = r_cols2;
  assign eng_mode    = r_mode;

  // Operand steering is purely combinational on the registered owner.
  assign eng_mat1       = req_mat1[int'(r_grant_id)*c_DW +: c_DW];
  assign eng_mat2       = req_mat2[int'(r_grant_id)*c_DW +: c_DW];
  assign eng_mat1_valid = r_grant_valid & req_mat1_valid[r_grant_id];
  assign eng_mat2_valid = r_grant_valid & req_mat2_valid[r_grant_id];

`ifdef MM_SCHED_TIMEOUT_EN
  assign eng_abort = r_eng_abort;
`else
  assign eng_abort = 1'b0;
`endif

endmodule
`default_nettype wire
